// File: rtl/daq_mem_arbiter.sv
// rtl/daq_mem_arbiter.sv - sample RAM arbiter between acquisition writes and host readout
//
// Purpose: shares one single-port sample RAM between the acquisition write
// path (requester A) and the host readout port (requester B). Acquisition
// normally wins ties. A hold counter makes sure a pending readout is granted
// after MAX_HOLD consecutive acquisition wins. All RAM-side and handshake
// outputs decode from the state register and the payload registers only.
//
// Build option: ARB_ROUND_ROBIN_EN. When it is defined, ties alternate
// between the two requesters, and the hold counter is not used.
//
// Ports:
//   new_clk, reset                 clock and synchronous active-high reset
//   acq_req/acq_addr/acq_wdata     write request, held until acq_gnt
//   acq_gnt                        write issued to RAM this cycle
//   rd_req/rd_addr                 readout request, held until rd_gnt
//   rd_gnt                         read issued to RAM this cycle
//   rd_data/rd_valid               captured read data and its one-cycle strobe
//   mem_en/mem_we/mem_addr/mem_wdata  RAM control
//   mem_rdata                      RAM read data, one cycle after a read enable
//   busy                           FSM is not idle
module daq_mem_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          new_clk,
  input  logic          reset,
  input  logic          acq_req,
  input  logic [AW-1:0] acq_addr,
  input  logic [DW-1:0] acq_wdata,
  output logic          acq_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDW} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          w_pick_acq;
  logic          w_pick_rd;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_rd;  // 1: readout won last; resets to readout so acquisition goes first
`else
  localparam logic [2:0] LP_MAX_HOLD = 3'(MAX_HOLD);
  logic [2:0] r_hold_cnt;
`endif

  // Arbitration decision; only acted on while idle.
  always_comb begin
    w_pick_acq = 1'b0;
    w_pick_rd  = 1'b0;
    if (acq_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (r_last_rd) w_pick_acq = 1'b1;
      else           w_pick_rd  = 1'b1;
`else
      if (r_hold_cnt < LP_MAX_HOLD) w_pick_acq = 1'b1;
      else                          w_pick_rd  = 1'b1;
`endif
    end else if (acq_req) begin
      w_pick_acq = 1'b1;
    end else if (rd_req) begin
      w_pick_rd = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge new_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_pick_acq)     w_next_state = S_WR;
        else if (w_pick_rd) w_next_state = S_RD;
        else                w_next_state = S_IDLE;
      end
      S_WR:    w_next_state = S_IDLE;
      S_RD:    w_next_state = S_RDW;
      S_RDW:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from registers only.
  always_comb begin
    acq_gnt   = (r_state == S_WR);
    rd_gnt    = (r_state == S_RD);
    mem_en    = (r_state == S_WR) || (r_state == S_RD);
    mem_we    = (r_state == S_WR);
    busy      = (r_state != S_IDLE);
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    rd_data   = r_rd_data;
    rd_valid  = r_rd_valid;
  end

  // Payload, read capture and arbitration history.
  always_ff @(posedge new_clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_rd  <= 1'b1;
`else
      r_hold_cnt <= 3'd0;
`endif
    end else begin
      // The RAM data for the read issued in RD is present during RDW.
      r_rd_valid <= (r_state == S_RDW);
      if (r_state == S_RDW) r_rd_data <= mem_rdata;
      if (r_state == S_IDLE) begin
        if (w_pick_acq) begin
          r_addr  <= acq_addr;
          r_wdata <= acq_wdata;
        end else if (w_pick_rd) begin
          r_addr <= rd_addr;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (w_pick_acq)     r_last_rd <= 1'b0;
        else if (w_pick_rd) r_last_rd <= 1'b1;
`else
        // An acquisition win with rd_req present is always below the limit here.
        if (w_pick_rd || !rd_req) r_hold_cnt <= 3'd0;
        else if (w_pick_acq)      r_hold_cnt <= r_hold_cnt + 3'd1;
`endif
      end
    end
  end

endmodule
